// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, runs the request/valid handshake to instruction memory and holds IF/ID.
// Optional illegal-opcode trap is built when ILLEGAL_OPCODE_TRAP_EN is defined.
module instruction_fetch #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] instrAddr,
  output logic                  instrRead,
  input  logic [31:0]           instrData,
  input  logic                  instrValid,
  input  logic                  stall,
  input  logic                  branch,
  input  logic [15:0]           branchOffset,
  output logic [31:0]           instruction,
  output logic [5:0]            opCode,
  output logic [ADDR_WIDTH-1:0] pcPlusOne,
  output logic                  fetchValid,
`ifdef ILLEGAL_OPCODE_TRAP_EN
  output logic                  illegalOpcode,
`endif
  output logic [1:0]            debugState
);

  // Handshake: a word transfers on a rising clk edge where instrRead && instrValid.
  // instrRead is held with a stable instrAddr until that edge; dropping it cancels the request.

`ifdef ILLEGAL_OPCODE_TRAP_EN
  typedef enum logic [1:0] {START = 2'd0, FETCH = 2'd1, REDIRECT = 2'd2, TRAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {START = 2'd0, FETCH = 2'd1, REDIRECT = 2'd2} state_t;
`endif

  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = RESET_PC[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] ONE        = 1;

  state_t                  state, stateNext;
  logic [ADDR_WIDTH-1:0]   pc, pcNext, pcPlusOneNext, branchTarget;
  logic [31:0]             instrNext;
  logic                    fetchValidNext;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic                    illegalNext;
`endif

  assign instrAddr    = pc;
  assign opCode       = instruction[31:26];
  assign debugState   = state;
  // Offset is relative to the branch's own successor; sign-extend or truncate to the PC width.
  assign branchTarget = pcPlusOne + ADDR_WIDTH'(signed'(branchOffset));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= START;
      pc          <= RESET_ADDR;
      instruction <= '0;
      pcPlusOne   <= '0;
      fetchValid  <= 1'b0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      illegalOpcode <= 1'b0;
`endif
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      instruction <= instrNext;
      pcPlusOne   <= pcPlusOneNext;
      fetchValid  <= fetchValidNext;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      illegalOpcode <= illegalNext;
`endif
    end
  end

  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    instrNext      = instruction;
    pcPlusOneNext  = pcPlusOne;
    fetchValidNext = fetchValid;
    instrRead      = 1'b0;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    illegalNext    = illegalOpcode;
`endif
    case (state)
      START: stateNext = FETCH;
      FETCH: begin
        instrRead = !stall;
        if (branch && fetchValid) begin
          // Taken branch wins over stall and over a word arriving this cycle.
          pcNext         = branchTarget;
          instrNext      = '0;
          fetchValidNext = 1'b0;
          stateNext      = REDIRECT;
        end else if (instrRead && instrValid) begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
          if (instrData[31:26] > 6'd3) begin
            instrNext      = '0;
            fetchValidNext = 1'b0;
            illegalNext    = 1'b1;
            stateNext      = TRAP;
          end else begin
            instrNext      = instrData;
            pcPlusOneNext  = pc + ONE;
            pcNext         = pc + ONE;
            fetchValidNext = 1'b1;
          end
`else
          instrNext      = instrData;
          pcPlusOneNext  = pc + ONE;
          pcNext         = pc + ONE;
          fetchValidNext = 1'b1;
`endif
        end else if (!stall) begin
          instrNext      = '0;
          fetchValidNext = 1'b0;
        end
      end
      REDIRECT: stateNext = FETCH;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      TRAP: stateNext = TRAP;
`endif
      default: stateNext = START;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, wait states, stall, branch, wrap, reset, opcode trap.
// Define ILLEGAL_OPCODE_TRAP_EN for both files to exercise the trap build.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  instrAddr;
  logic        instrRead;
  logic [31:0] instrData;
  logic        instrValid;
  logic        stall;
  logic        branch;
  logic [15:0] branchOffset;
  logic [31:0] instruction;
  logic [5:0]  opCode;
  logic [7:0]  pcPlusOne;
  logic        fetchValid;
  logic [1:0]  debugState;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic        illegalOpcode;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_WIDTH(8), .RESET_PC(0)) dut (
    .clk(clk),
    .reset(reset),
    .instrAddr(instrAddr),
    .instrRead(instrRead),
    .instrData(instrData),
    .instrValid(instrValid),
    .stall(stall),
    .branch(branch),
    .branchOffset(branchOffset),
    .instruction(instruction),
    .opCode(opCode),
    .pcPlusOne(pcPlusOne),
    .fetchValid(fetchValid),
`ifdef ILLEGAL_OPCODE_TRAP_EN
    .illegalOpcode(illegalOpcode),
`endif
    .debugState(debugState)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [7:0] ppo,
                          input logic fv, input logic [7:0] addr);
    chk({tag, "_instr"}, instruction, ins);
    chk({tag, "_op"}, 32'(opCode), 32'(ins[31:26]));
    chk({tag, "_ppo"}, 32'(pcPlusOne), 32'(ppo));
    chk({tag, "_fv"}, 32'(fetchValid), 32'(fv));
    chk({tag, "_addr"}, 32'(instrAddr), 32'(addr));
  endtask

  initial begin
    reset = 1'b1; instrData = '0; instrValid = 1'b0; stall = 1'b0;
    branch = 1'b0; branchOffset = '0;
    tick(); tick();
    chk_ifid("reset", 32'h0, 8'd0, 1'b0, 8'd0);
    chk("reset_rd", 32'(instrRead), 32'd0);
    chk("reset_st", 32'(debugState), 32'd0);

    // Sequential fetch: one idle START cycle, then the request.
    reset = 1'b0; #1;
    chk("start_rd", 32'(instrRead), 32'd0);
    tick();
    chk("fetch_rd", 32'(instrRead), 32'd1);
    chk("fetch_addr", 32'(instrAddr), 32'd0);
    tick();
    chk("bubble_fv", 32'(fetchValid), 32'd0);
    instrValid = 1'b1; instrData = 32'h0400_0000;
    tick();
    chk_ifid("seq0", 32'h0400_0000, 8'd1, 1'b1, 8'd1);
    instrData = 32'h0800_0000;
    tick();
    chk_ifid("seq1", 32'h0800_0000, 8'd2, 1'b1, 8'd2);

    // Stall: memory keeps offering a word, nothing may be captured.
    stall = 1'b1; instrData = 32'hDEAD_BEEF; #1;
    chk("stall_rd", 32'(instrRead), 32'd0);
    repeat (4) begin
      tick();
      chk_ifid("stall", 32'h0800_0000, 8'd2, 1'b1, 8'd2);
      chk("stall_rd_hold", 32'(instrRead), 32'd0);
    end
    stall = 1'b0; instrValid = 1'b0; #1;
    chk("resume_rd", 32'(instrRead), 32'd1);
    chk("resume_addr", 32'(instrAddr), 32'd2);

    // Multi-cycle memory: three wait cycles with the request held.
    repeat (3) begin
      tick();
      chk_ifid("wait", 32'h0, 8'd2, 1'b0, 8'd2);
      chk("wait_rd", 32'(instrRead), 32'd1);
    end
    instrValid = 1'b1; instrData = 32'h0000_0001;
    tick();
    chk_ifid("mc0", 32'h0000_0001, 8'd3, 1'b1, 8'd3);
    instrData = 32'h0000_0002;
    tick();
    chk_ifid("mc1", 32'h0000_0002, 8'd4, 1'b1, 8'd4);
    instrData = 32'h0C00_FFFD;
    tick();
    chk_ifid("beq", 32'h0C00_FFFD, 8'd5, 1'b1, 8'd5);

    // Taken branch with a word arriving the same cycle: 5 - 3 = 2, word dropped.
    branch = 1'b1; branchOffset = 16'hFFFD; instrData = 32'h1111_1111;
    tick();
    chk_ifid("br", 32'h0, 8'd5, 1'b0, 8'd2);
    chk("br_rd", 32'(instrRead), 32'd0);
    chk("br_st", 32'(debugState), 32'd2);
    branch = 1'b0;
    tick();
    chk_ifid("redir", 32'h0, 8'd5, 1'b0, 8'd2);
    chk("redir_rd", 32'(instrRead), 32'd1);
    instrData = 32'h0000_0003;
    tick();
    chk_ifid("tgt", 32'h0000_0003, 8'd3, 1'b1, 8'd3);

    // Forward branch to the top of the address space: 3 + 252 = 255.
    branch = 1'b1; branchOffset = 16'h00FC;
    tick();
    chk("fwd_addr", 32'(instrAddr), 32'd255);
    branch = 1'b0; instrValid = 1'b0;
    tick();
    // Branch with an empty IF/ID is ignored.
    branch = 1'b1; branchOffset = 16'h0010;
    tick();
    chk_ifid("nobr", 32'h0, 8'd3, 1'b0, 8'd255);
    chk("nobr_st", 32'(debugState), 32'd1);
    branch = 1'b0; instrValid = 1'b1; instrData = 32'h0400_0005;
    tick();
    chk_ifid("wrap", 32'h0400_0005, 8'd0, 1'b1, 8'd0);

    // Backward branch from pcPlusOne=0 wraps to 255 and beats stall.
    branch = 1'b1; branchOffset = 16'hFFFF; stall = 1'b1;
    tick();
    chk_ifid("bwrap", 32'h0, 8'd0, 1'b0, 8'd255);
    branch = 1'b0; stall = 1'b0;

    // Reset mid-handshake with valid and branch asserted.
    instrValid = 1'b1; branch = 1'b1; reset = 1'b1;
    tick();
    chk_ifid("rst2", 32'h0, 8'd0, 1'b0, 8'd0);
    chk("rst2_rd", 32'(instrRead), 32'd0);
    reset = 1'b0; branch = 1'b0; instrValid = 1'b0;
    tick();
    chk("rst2_fetch", 32'(instrRead), 32'd1);
    instrValid = 1'b1; instrData = 32'hFC00_0000;
    tick();
`ifdef ILLEGAL_OPCODE_TRAP_EN
    chk_ifid("trap", 32'h0, 8'd0, 1'b0, 8'd0);
    chk("trap_ill", 32'(illegalOpcode), 32'd1);
    chk("trap_rd", 32'(instrRead), 32'd0);
    chk("trap_st", 32'(debugState), 32'd3);
    branch = 1'b1; branchOffset = 16'h0004;
    repeat (2) begin
      tick();
      chk("trap_hold_rd", 32'(instrRead), 32'd0);
      chk("trap_hold_addr", 32'(instrAddr), 32'd0);
      chk("trap_hold_ill", 32'(illegalOpcode), 32'd1);
    end
    branch = 1'b0; reset = 1'b1;
    tick();
    chk("trap_clr", 32'(illegalOpcode), 32'd0);
    chk("trap_clr_st", 32'(debugState), 32'd0);
    reset = 1'b0;
`else
    chk_ifid("op63", 32'hFC00_0000, 8'd1, 1'b1, 8'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
